// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller.
package mbist_pkg;

    localparam int ELEM_CNT = 6;

    // March element encoding, in execution order.
    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } march_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mbist_state_e;

    // M3..M5 walk the address space downwards.
    function automatic logic elem_is_down(input march_elem_e e);
        return (e == M3) || (e == M4) || (e == M5);
    endfunction

    // M0 (w0) and M5 (r0) are single-op elements; the rest are read-then-write.
    function automatic logic elem_has_two_ops(input march_elem_e e);
        return (e != M0) && (e != M5);
    endfunction

endpackage

// File: rtl/mbist_march_seq.sv
// March C- sequencer: walks background, element, address and op phase,
// presenting the op that will be issued next. The state wraps back to its
// reset value after the final op, so it is ready for the next run.
module mbist_march_seq
    import mbist_pkg::*;
#(
    parameter int                 ADDR_W = 12,
    parameter int                 DATA_W = 32,
    parameter int                 DEPTH  = 4096,
    parameter logic [DATA_W-1:0]  BG1    = DATA_W'(32'h5555_5555)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output march_op_e         op,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern,
    output march_elem_e       elem,
    output logic              bg,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam march_elem_e       ELEM_LAST = march_elem_e'(3'(ELEM_CNT - 1));

    march_elem_e       elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              bg_q, bg_d;

    logic              at_term;
    logic              elem_end;
    logic              invert;
    logic [DATA_W-1:0] bg_word;

    // Decode the current position into op type, data polarity and end flags.
    always_comb begin
        bg_word  = bg_q ? BG1 : '0;
        at_term  = elem_is_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
        elem_end = at_term && (!elem_has_two_ops(elem_q) || phase_q);
        op       = OP_WR;
        invert   = 1'b0;
        case (elem_q)
            M0: begin
                op     = OP_WR;
                invert = 1'b0;
            end
            M1, M3: begin
                op     = phase_q ? OP_WR : OP_RD;
                invert = phase_q;
            end
            M2, M4: begin
                op     = phase_q ? OP_WR : OP_RD;
                invert = !phase_q;
            end
            M5: begin
                op     = OP_RD;
                invert = 1'b0;
            end
            default: begin
                op     = OP_WR;
                invert = 1'b0;
            end
        endcase
        pattern = invert ? ~bg_word : bg_word;
        addr    = addr_q;
        elem    = elem_q;
        bg      = bg_q;
        last    = bg_q && elem_end && (elem_q == ELEM_LAST);
    end

    // Step phase, then address, then element, then background.
    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        bg_d    = bg_q;
        if (advance) begin
            if (elem_has_two_ops(elem_q) && !phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!at_term) begin
                    addr_d = elem_is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
                end else if (elem_q == ELEM_LAST) begin
                    elem_d = M0;
                    addr_d = '0;
                    bg_d   = !bg_q;
                end else begin
                    elem_d = march_elem_e'(elem_q + 3'd1);
                    addr_d = elem_is_down(elem_d) ? ADDR_LAST : '0;
                end
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q  <= M0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            bg_q    <= 1'b0;
        end else begin
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            bg_q    <= bg_d;
        end
    end

endmodule

// File: rtl/sram_mbist_ctrl.sv
// March C- BIST controller for a single-port SRAM: run FSM, registered
// SRAM pins and the one-cycle read-compare pipeline with first-fail capture.
//
// state    | meaning
// ST_IDLE  | SRAM released, waiting for start
// ST_RUN   | one March op on the pins every cycle
// ST_DRAIN | pins parked, final read compare pending
// ST_DONE  | like idle, done held high
module sram_mbist_ctrl
    import mbist_pkg::*;
#(
    parameter int                 ADDR_W = 12,
    parameter int                 DATA_W = 32,
    parameter int                 DEPTH  = 4096,
    parameter logic [DATA_W-1:0]  BG1    = DATA_W'(32'h5555_5555)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              fail_bg,
    output logic [DATA_W-1:0] fail_data,
    output logic              BIST,
    output logic              CEBM,
    output logic              WEBM,
    output logic [ADDR_W-1:0] AM,
    output logic [DATA_W-1:0] DM,
    output logic [DATA_W-1:0] BWEBM,
    input  logic [DATA_W-1:0] Q
);

    mbist_state_e      state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic              fail_bg_q, fail_bg_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic              bist_q, bist_d;
    logic              cebm_q, cebm_d;
    logic              webm_q, webm_d;
    logic [ADDR_W-1:0] am_q, am_d;
    logic [DATA_W-1:0] dm_q, dm_d;

    // Side information travelling with the op currently on the pins.
    logic              pin_rd_q, pin_rd_d;
    logic [DATA_W-1:0] pin_exp_q, pin_exp_d;
    logic [2:0]        pin_elem_q, pin_elem_d;
    logic              pin_bg_q, pin_bg_d;
    logic              last_q, last_d;

    // Read captured at the previous edge, compared against Q at this edge.
    logic              cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;
    logic              cmp_bg_q, cmp_bg_d;

    logic              issue;
    logic              mismatch;
    march_op_e         seq_op;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_pattern;
    march_elem_e       seq_elem;
    logic              seq_bg;
    logic              seq_last;

    mbist_march_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BG1    (BG1)
    ) u_seq (
        .clk     (CLK),
        .rst     (RST),
        .advance (issue),
        .op      (seq_op),
        .addr    (seq_addr),
        .pattern (seq_pattern),
        .elem    (seq_elem),
        .bg      (seq_bg),
        .last    (seq_last)
    );

    // Next-state, pin and compare logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_bg_d   = fail_bg_q;
        fail_data_d = fail_data_q;
        bist_d      = bist_q;
        cebm_d      = cebm_q;
        webm_d      = webm_q;
        am_d        = am_q;
        dm_d        = dm_q;
        pin_rd_d    = pin_rd_q;
        pin_exp_d   = pin_exp_q;
        pin_elem_d  = pin_elem_q;
        pin_bg_d    = pin_bg_q;
        last_d      = last_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        cmp_bg_d    = cmp_bg_q;
        issue       = 1'b0;
        mismatch    = cmp_vld_q && (Q != cmp_exp_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    bist_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_bg_d   = 1'b0;
                    fail_data_d = '0;
                    issue       = 1'b1;
                end
            end
            ST_RUN: begin
                cmp_vld_d  = pin_rd_q;
                cmp_exp_d  = pin_exp_q;
                cmp_addr_d = am_q;
                cmp_elem_d = pin_elem_q;
                cmp_bg_d   = pin_bg_q;
                if (last_q) begin
                    state_d  = ST_DRAIN;
                    cebm_d   = 1'b1;
                    webm_d   = 1'b1;
                    am_d     = '0;
                    dm_d     = '0;
                    pin_rd_d = 1'b0;
                    last_d   = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                bist_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            cebm_d     = 1'b0;
            webm_d     = (seq_op == OP_RD);
            am_d       = seq_addr;
            dm_d       = (seq_op == OP_RD) ? '0 : seq_pattern;
            pin_rd_d   = (seq_op == OP_RD);
            pin_exp_d  = seq_pattern;
            pin_elem_d = seq_elem;
            pin_bg_d   = seq_bg;
            last_d     = seq_last;
        end

        // A pending compare can never coincide with an accepted start, so the
        // clear above and the capture below do not collide.
        if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
                fail_bg_d   = cmp_bg_q;
                fail_data_d = Q;
            end
        end
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bg_q   <= 1'b0;
            fail_data_q <= '0;
            bist_q      <= 1'b0;
            cebm_q      <= 1'b1;
            webm_q      <= 1'b1;
            am_q        <= '0;
            dm_q        <= '0;
            pin_rd_q    <= 1'b0;
            pin_exp_q   <= '0;
            pin_elem_q  <= '0;
            pin_bg_q    <= 1'b0;
            last_q      <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            cmp_bg_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_bg_q   <= fail_bg_d;
            fail_data_q <= fail_data_d;
            bist_q      <= bist_d;
            cebm_q      <= cebm_d;
            webm_q      <= webm_d;
            am_q        <= am_d;
            dm_q        <= dm_d;
            pin_rd_q    <= pin_rd_d;
            pin_exp_q   <= pin_exp_d;
            pin_elem_q  <= pin_elem_d;
            pin_bg_q    <= pin_bg_d;
            last_q      <= last_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            cmp_bg_q    <= cmp_bg_d;
        end
    end

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_fail = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_bg   = fail_bg_q;
    assign fail_data = fail_data_q;
    assign BIST      = bist_q;
    assign CEBM      = cebm_q;
    assign WEBM      = webm_q;
    assign AM        = am_q;
    assign DM        = dm_q;
    assign BWEBM     = '0;

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Bench for sram_mbist_ctrl: behavioural 1-cycle SRAM with injectable faults,
// a table of full runs with expected results, and hand-written sequences for
// reset, re-pulsed start and mid-run reset. DEPTH is reduced to 256 so the
// whole set of runs stays short; all other parameters are the defaults.
module tb_sram_mbist_ctrl;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 256;
    localparam int RUN_EDGES = 20 * DEPTH + 1;
    localparam int EDGE_MAX  = RUN_EDGES + 200;

    // fault modes of the SRAM model
    localparam int F_NONE = 0;
    localparam int F_SA1  = 1;   // bit 5 of 0x07F reads as 1
    localparam int F_SA0  = 2;   // bit 0 of 0x000 reads as 0
    localparam int F_CPL  = 3;   // write to 0x001 flips bit 31 of 0x000

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic              bist_busy, bist_done, bist_fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic              fail_bg;
    logic [DATA_W-1:0] fail_data;
    logic              BIST, CEBM, WEBM;
    logic [ADDR_W-1:0] AM;
    logic [DATA_W-1:0] DM, BWEBM;
    logic [DATA_W-1:0] Q = '0;

    logic [DATA_W-1:0] mem [0:4095];
    int                fault_mode = F_NONE;
    int                n_vec = 0;
    int                n_err = 0;

    typedef struct {
        string             name;
        int                fault;
        bit                repulse;
        bit                exp_fail;
        logic [ADDR_W-1:0] exp_addr;
        logic [2:0]        exp_elem;
        bit                exp_bg;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    always #5 CLK = ~CLK;

    sram_mbist_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .bist_busy (bist_busy),
        .bist_done (bist_done),
        .bist_fail (bist_fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_bg   (fail_bg),
        .fail_data (fail_data),
        .BIST      (BIST),
        .CEBM      (CEBM),
        .WEBM      (WEBM),
        .AM        (AM),
        .DM        (DM),
        .BWEBM     (BWEBM),
        .Q         (Q)
    );

    function automatic logic [DATA_W-1:0] sram_read(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
        if (fault_mode == F_SA1 && a == 12'h07F) r = r | 32'h0000_0020;
        if (fault_mode == F_SA0 && a == 12'h000) r = r & 32'hFFFF_FFFE;
        return r;
    endfunction

    // SRAM model: write or read at the rising edge, Q valid the next cycle.
    always @(posedge CLK) begin
        if (!CEBM) begin
            if (!WEBM) begin
                mem[AM] <= DM;
                if (fault_mode == F_CPL && AM == 12'h001)
                    mem[0] <= mem[0] ^ 32'h8000_0000;
            end else begin
                Q <= sram_read(AM, mem[AM]);
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start, check the first op, then count edges until done.
    task automatic run_test(input bit repulse, output int edges);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        check("start_busy",  64'(bist_busy), 64'd1);
        check("start_bist",  64'(BIST),      64'd1);
        check("start_done",  64'(bist_done), 64'd0);
        check("start_fail",  64'(bist_fail), 64'd0);
        check("start_faddr", 64'(fail_addr), 64'd0);
        check("start_felem", 64'(fail_elem), 64'd0);
        check("start_fbg",   64'(fail_bg),   64'd0);
        check("start_fdata", 64'(fail_data), 64'd0);
        check("op0_cebm",    64'(CEBM),      64'd0);
        check("op0_webm",    64'(WEBM),      64'd0);
        check("op0_am",      64'(AM),        64'd0);
        check("op0_dm",      64'(DM),        64'd0);
        while (!bist_done && edges < EDGE_MAX) begin
            if (repulse && edges == 1000) start = 1'b1;
            tick();
            start = 1'b0;
            edges++;
        end
        check("done_edges", 64'(edges),     64'(RUN_EDGES));
        check("end_done",   64'(bist_done), 64'd1);
        check("end_busy",   64'(bist_busy), 64'd0);
        check("end_bist",   64'(BIST),      64'd0);
        check("end_cebm",   64'(CEBM),      64'd1);
    endtask

    initial begin
        int edges;

        vecs[0] = '{"clean_repulse", F_NONE, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0, 32'h0000_0000};
        vecs[1] = '{"sa1_b5_07f",    F_SA1,  1'b0, 1'b1, 12'h07F, 3'd1, 1'b0, 32'h0000_0020};
        vecs[2] = '{"sa0_b0_000",    F_SA0,  1'b0, 1'b1, 12'h000, 3'd2, 1'b0, 32'hFFFF_FFFE};
        vecs[3] = '{"coupling",      F_CPL,  1'b0, 1'b1, 12'h000, 3'd1, 1'b0, 32'h8000_0000};
        vecs[4] = '{"clean_rerun",   F_NONE, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 32'h0000_0000};

        RST   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("rst_bist",  64'(BIST),      64'd0);
        check("rst_cebm",  64'(CEBM),      64'd1);
        check("rst_webm",  64'(WEBM),      64'd1);
        check("rst_am",    64'(AM),        64'd0);
        check("rst_dm",    64'(DM),        64'd0);
        check("rst_bwebm", 64'(BWEBM),     64'd0);
        check("rst_busy",  64'(bist_busy), 64'd0);
        check("rst_done",  64'(bist_done), 64'd0);
        check("rst_fail",  64'(bist_fail), 64'd0);
        check("rst_faddr", 64'(fail_addr), 64'd0);
        check("rst_fdata", 64'(fail_data), 64'd0);
        RST = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            fault_mode = vecs[v].fault;
            run_test(vecs[v].repulse, edges);
            check({vecs[v].name, "_fail"},  64'(bist_fail), 64'(vecs[v].exp_fail));
            check({vecs[v].name, "_faddr"}, 64'(fail_addr), 64'(vecs[v].exp_addr));
            check({vecs[v].name, "_felem"}, 64'(fail_elem), 64'(vecs[v].exp_elem));
            check({vecs[v].name, "_fbg"},   64'(fail_bg),   64'(vecs[v].exp_bg));
            check({vecs[v].name, "_fdata"}, 64'(fail_data), 64'(vecs[v].exp_data));
            repeat (3) tick();
            check({vecs[v].name, "_done_sticky"}, 64'(bist_done), 64'd1);
            check({vecs[v].name, "_fail_sticky"}, 64'(bist_fail), 64'(vecs[v].exp_fail));
        end

        // Reset while op 5000 is on the pins, then a fresh clean run.
        fault_mode = F_NONE;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (edges < 5000) begin
            tick();
            edges++;
        end
        check("op5000_busy", 64'(bist_busy), 64'd1);
        check("op5000_cebm", 64'(CEBM),      64'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_bist", 64'(BIST),      64'd0);
        check("midrst_cebm", 64'(CEBM),      64'd1);
        check("midrst_webm", 64'(WEBM),      64'd1);
        check("midrst_am",   64'(AM),        64'd0);
        check("midrst_busy", 64'(bist_busy), 64'd0);
        check("midrst_done", 64'(bist_done), 64'd0);
        tick();
        check("postrst_busy", 64'(bist_busy), 64'd0);
        run_test(1'b0, edges);
        check("postrst_fail",  64'(bist_fail), 64'd0);
        check("postrst_faddr", 64'(fail_addr), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
